// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 32;
    localparam int unsigned BCW    = $clog2(NREG + 1);

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } rf_wr_t;

    // Owner of the write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_LW
    } grant_e;

    // Number of set bits in a scoreboard mask.
    function automatic logic [BCW-1:0] count_busy(input logic [NREG-1:0] mask);
        logic [BCW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            n = n + BCW'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Write-back / long-latency result / regfile write bus of the arbiter.
interface regfile_wport_arbiter_if;
    import rf_arb_pkg::*;

    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              lw_valid;
    logic [REG_AW-1:0] lw_rd;
    logic [XLEN-1:0]   lw_data;
    logic              lw_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;

    // Producer side: pipeline WB and LW source, observer of the regfile write.
    modport master (
        output wb_we, wb_rd, wb_data, lw_valid, lw_rd, lw_data,
        input  lw_ready, rf_we, rf_rd, rf_wdata
    );

    // Arbiter side.
    modport slave (
        input  wb_we, wb_rd, wb_data, lw_valid, lw_rd, lw_data,
        output lw_ready, rf_we, rf_rd, rf_wdata
    );

endinterface

// File: rtl/rf_arb_fifo.sv
// Pending long-latency result FIFO; pointers wrap modulo DEPTH.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         Rst_n,
    input  logic                         push,
    input  rf_wr_t                       push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output rf_wr_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rf_wr_t          mem_q [DEPTH];
    rf_wr_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next storage, pointers and occupancy from push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single regfile write port shared between in-order WB and out-of-order LW
// results, with a busy scoreboard for decode stalls and a starvation monitor.
module regfile_wport_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     Rst_n,
    input  logic                     mem_hold,
    regfile_wport_arbiter_if.slave   bus,
    input  logic                     iss_valid,
    input  logic [REG_AW-1:0]        iss_rd,
    input  logic [REG_AW-1:0]        chk_rs1,
    input  logic [REG_AW-1:0]        chk_rs2,
    input  logic [REG_AW-1:0]        chk_rd,
    output logic                     stall,
    output logic                     wb_bubble_req,
    output logic [NREG-1:0]          busy_mask,
    output logic                     err_waw
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BCW-1:0] BUSY_CAP = BCW'(DEPTH + 2);

    grant_e          grant;
    logic            fifo_full, fifo_empty, push, pop, issue;
    rf_wr_t          fifo_head, push_data;
    logic [CW-1:0]   fifo_count;
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW-1:0]   age_q, age_d;
    logic            err_q, err_d;

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .Rst_n     (Rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Port grant, regfile write mux, LW handshake and decode stall.
    always_comb begin
        grant = GNT_NONE;
        if (bus.wb_we && (bus.wb_rd != '0)) begin
            grant = GNT_WB;
        end else if (!fifo_empty) begin
            grant = GNT_LW;
        end
        bus.rf_we    = (grant != GNT_NONE);
        bus.rf_rd    = '0;
        bus.rf_wdata = '0;
        if (grant == GNT_WB) begin
            bus.rf_rd    = bus.wb_rd;
            bus.rf_wdata = bus.wb_data;
        end else if (grant == GNT_LW) begin
            bus.rf_rd    = fifo_head.rd;
            bus.rf_wdata = fifo_head.data;
        end
        bus.lw_ready   = (fifo_count < CW'(DEPTH));
        // x0 results are acknowledged but never occupy an entry.
        push           = bus.lw_valid && !fifo_full && (bus.lw_rd != '0);
        push_data.rd   = bus.lw_rd;
        push_data.data = bus.lw_data;
        pop            = (grant == GNT_LW) && !mem_hold;
        stall = busy_q[chk_rs1] || busy_q[chk_rs2] || busy_q[chk_rd]
             || (iss_valid && (count_busy(busy_q) >= BUSY_CAP));
        issue = iss_valid && !stall && (iss_rd != '0);
    end

    // Scoreboard, starvation age and sticky WAW error next state.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[fifo_head.rd] = 1'b0;
        end
        // Applied after the clear so a same-register set wins.
        if (issue) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        age_d = age_q;
        if (fifo_empty || pop) begin
            age_d = '0;
        end else if (!mem_hold && (age_q != AW'(STARVE_LIMIT))) begin
            age_d = age_q + 1'b1;
        end

        err_d = err_q || ((grant == GNT_WB) && !mem_hold && busy_q[bus.wb_rd]);
    end

    // State registers.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_q <= '0;
            age_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask     = busy_q;
    assign wb_bubble_req = (age_q >= AW'(STARVE_LIMIT));
    assign err_waw       = err_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomized and directed stimulus for regfile_wport_arbiter checked against
// a queue/array reference model of the write-port rules.
module tb_regfile_wport_arbiter;
    import rf_arb_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 8;

    logic             clk = 1'b0;
    logic             Rst_n = 1'b0;
    logic             mem_hold, iss_valid;
    logic [4:0]       iss_rd, chk_rs1, chk_rs2, chk_rd;
    logic             stall, wb_bubble_req, err_waw;
    logic [NREG-1:0]  busy_mask;

    regfile_wport_arbiter_if bus ();

    regfile_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .Rst_n         (Rst_n),
        .mem_hold      (mem_hold),
        .bus           (bus.slave),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .chk_rs1       (chk_rs1),
        .chk_rs2       (chk_rs2),
        .chk_rd        (chk_rd),
        .stall         (stall),
        .wb_bubble_req (wb_bubble_req),
        .busy_mask     (busy_mask),
        .err_waw       (err_waw)
    );

    always #5 clk = ~clk;

    // Reference model state
    rf_wr_t      mq[$];
    bit          mbusy[NREG];
    int unsigned mage;
    bit          merr;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        mage = 0;
        merr = 1'b0;
    endtask

    task automatic idle();
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.lw_valid = 0; bus.lw_rd = 0; bus.lw_data = 0;
        mem_hold = 0; iss_valid = 0; iss_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    // Compare DUT outputs against the model for the current inputs; when
    // advance is set, also move the model across the coming clock edge.
    task automatic compare_and_step(input bit advance);
        int unsigned     nb;
        bit              wbw, e_we, e_ready, e_stall, hcommit, issue;
        logic [4:0]      e_rd;
        logic [31:0]     e_data;
        logic [NREG-1:0] e_mask;
        nb = 0;
        for (int i = 0; i < NREG; i++) begin
            e_mask[i] = mbusy[i];
            nb += mbusy[i];
        end
        wbw     = bus.wb_we && (bus.wb_rd != 0);
        e_we    = wbw || (mq.size() > 0);
        e_rd    = wbw ? bus.wb_rd : (mq.size() > 0 ? mq[0].rd : 5'd0);
        e_data  = wbw ? bus.wb_data : (mq.size() > 0 ? mq[0].data : 32'd0);
        e_ready = (mq.size() < DEPTH);
        e_stall = mbusy[chk_rs1] || mbusy[chk_rs2] || mbusy[chk_rd]
               || (iss_valid && nb >= DEPTH + 2);
        check_eq("rf_we", 64'(bus.rf_we), 64'(e_we));
        if (e_we) begin
            check_eq("rf_rd", 64'(bus.rf_rd), 64'(e_rd));
            check_eq("rf_wdata", 64'(bus.rf_wdata), 64'(e_data));
        end
        check_eq("lw_ready", 64'(bus.lw_ready), 64'(e_ready));
        check_eq("stall", 64'(stall), 64'(e_stall));
        check_eq("bubble", 64'(wb_bubble_req), 64'(mage >= LIMIT));
        check_eq("busy_mask", 64'(busy_mask), 64'(e_mask));
        check_eq("err_waw", 64'(err_waw), 64'(merr));
        if (!advance) return;
        hcommit = e_we && !wbw && !mem_hold;
        issue   = iss_valid && !e_stall && (iss_rd != 0);
        if (e_we && wbw && !mem_hold && mbusy[bus.wb_rd]) merr = 1'b1;
        if (mq.size() == 0 || hcommit) mage = 0;
        else if (!mem_hold) mage++;
        if (hcommit) begin
            mbusy[mq[0].rd] = 1'b0;
            void'(mq.pop_front());
        end
        if (issue) mbusy[iss_rd] = 1'b1;
        if (bus.lw_valid && e_ready && bus.lw_rd != 0)
            mq.push_back('{rd: bus.lw_rd, data: bus.lw_data});
    endtask

    // One cycle: inputs already driven; check on negedge, step on posedge.
    task automatic tick();
        @(negedge clk);
        compare_and_step(1'b1);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must fall to reset values at once.
    task automatic do_reset();
        idle();
        Rst_n = 1'b0;
        #2;
        model_clear();
        compare_and_step(1'b0);
        @(posedge clk);
        #1;
        compare_and_step(1'b0);
        Rst_n = 1'b1;
    endtask

    task automatic issue_reg(input logic [4:0] r);
        idle(); iss_valid = 1; iss_rd = r; tick();
    endtask

    initial begin
        logic [4:0] r;
        idle();
        do_reset();

        // LW alone: issue x5, result arrives, commits next cycle
        issue_reg(5);
        idle(); bus.lw_valid = 1; bus.lw_rd = 5; bus.lw_data = 32'hDEADBEEF; chk_rs1 = 5;
        tick();
        idle(); chk_rs1 = 5;
        tick(); tick();

        // Contention: WB every cycle while an LW result waits
        issue_reg(7);
        idle(); bus.lw_valid = 1; bus.lw_rd = 7; bus.lw_data = 32'h0000_7777;
        bus.wb_we = 1; bus.wb_rd = 3; bus.wb_data = $urandom;
        tick();
        bus.lw_valid = 0;
        for (int i = 0; i < 10; i++) begin bus.wb_data = $urandom; tick(); end
        idle(); tick(); tick();

        // Full FIFO with the port blocked by WB
        idle(); bus.wb_we = 1; bus.wb_rd = 2;
        for (int i = 0; i < 3; i++) begin
            bus.lw_valid = 1; bus.lw_rd = 5'(10 + i); bus.lw_data = $urandom; tick();
        end
        bus.wb_we = 0; tick(); tick();
        bus.lw_valid = 0;
        for (int i = 0; i < 4; i++) tick();

        // mem_hold freezes the queued head
        issue_reg(13);
        idle(); bus.lw_valid = 1; bus.lw_rd = 13; bus.lw_data = 32'h1313_1313; tick();
        idle(); mem_hold = 1; chk_rs2 = 13;
        for (int i = 0; i < 3; i++) tick();
        mem_hold = 0; tick(); tick();

        // x0 result discarded; WB to busy register latches err_waw
        idle(); bus.lw_valid = 1; bus.lw_rd = 0; bus.lw_data = 32'hFFFF_FFFF; tick();
        idle(); tick();
        issue_reg(9);
        idle(); bus.wb_we = 1; bus.wb_rd = 9; bus.wb_data = 32'h9999; tick();
        idle(); for (int i = 0; i < 3; i++) tick();

        // Reset with two queued results: they must never be written
        issue_reg(20);
        issue_reg(21);
        idle(); bus.wb_we = 1; bus.wb_rd = 4;
        bus.lw_valid = 1; bus.lw_rd = 20; bus.lw_data = 32'h2020; tick();
        bus.lw_rd = 21; bus.lw_data = 32'h2121; tick();
        do_reset();
        for (int i = 0; i < 3; i++) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            bus.wb_we    = ($urandom_range(0, 1) == 1);
            bus.wb_rd    = 5'($urandom_range(0, 31));
            bus.wb_data  = $urandom;
            bus.lw_valid = ($urandom_range(0, 9) < 4);
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 8) begin
                for (int k = 0; k < 8; k++) begin
                    r = 5'($urandom_range(1, 31));
                    if (mbusy[r]) break;
                end
            end
            bus.lw_rd    = r;
            bus.lw_data  = $urandom;
            iss_valid    = ($urandom_range(0, 9) < 3);
            iss_rd       = 5'($urandom_range(0, 31));
            chk_rs1      = 5'($urandom_range(0, 31));
            chk_rs2      = 5'($urandom_range(0, 31));
            chk_rd       = 5'($urandom_range(0, 31));
            mem_hold     = ($urandom_range(0, 99) < 15);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
